uart_bus_sched: RTL and testbench
=================================

UART_BUS_SCHED -- requirements
Module: uart_bus_sched

Interface
REQ-001 Parameter BAUD_RESET, 16'd24, baud divisor written at power-up configuration.
REQ-002 Parameter CTRL_RESET, 32'h0, control word written to the UART control register at configuration.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 nReset  input  1  reset, synchronous, active-high (1 = reset), despite the name.
REQ-005 req_valid  input  2  per-requester transaction request; bit i = requester i.
REQ-006 req_wen  input  2  per-requester 1 = write, 0 = read.
REQ-007 req_addr  input  2x32  per-requester UART register address.
REQ-008 req_wdata  input  2x32  per-requester write data.
REQ-009 req_ready  output  2  one-hot acceptance pulse; request i taken this cycle.
REQ-010 rsp_valid  output  2  one-hot completion pulse to the granted requester.
REQ-011 rsp_rdata  output  32  read data, valid with rsp_valid.
REQ-012 rsp_error  output  1  bus error on the completed transaction, valid with rsp_valid.
REQ-013 cfg_start  input  1  pulse; rerun configuration using cfg_baud.
REQ-014 cfg_baud  input  16  baud divisor for a cfg_start run.
REQ-015 cfg_done  output  1  high when configuration has completed and no config run is pending.
REQ-016 cfg_err  output  1  sticky: a configuration write saw bus_error.
REQ-017 bus_addr, bus_wdata  output  32 each  master side of the UART peripheral bus.
REQ-018 bus_wen, bus_ren  output  1 each  bus write/read enables; never both high.
REQ-019 bus_strobe  output  4  byte strobe; 4'hF on every access.
REQ-020 bus_rdata  input  32; bus_request_stall  input  1; bus_error  input  1.

Function
REQ-021 FSM states: CFG_BAUD, CFG_CTRL, IDLE, XFER, RESP.
REQ-022 CFG_BAUD: write {16'h0, divisor} to UART_BAUD_ADDR; hold until bus_request_stall=0, then go to CFG_CTRL.
REQ-023 CFG_CTRL: write CTRL_RESET to UART_CTRL_ADDR; hold until bus_request_stall=0, then go to IDLE and set cfg_done.
REQ-024 Divisor is BAUD_RESET after reset and cfg_baud (captured on the cfg_start cycle) for a cfg_start run.
REQ-025 bus_error on a config completion cycle sets cfg_err; the sequence continues regardless.
REQ-026 cfg_start is latched as pending in any state and clears cfg_done; in IDLE, pending config takes priority over requesters.
REQ-027 IDLE arbitration is round-robin over the two requesters; the requester not granted last has priority; after reset requester 0 has priority.
REQ-028 Grant in IDLE in cycle N: pulse req_ready[i], register addr/wen/wdata, go to XFER; bus signals are asserted starting cycle N+1.
REQ-029 XFER: hold bus signals stable while bus_request_stall=1; the completion cycle M is the first cycle with stall=0, in which bus_rdata and bus_error are captured.
REQ-030 RESP (cycle M+1): pulse rsp_valid[i] with captured data/error, then go to IDLE; a new grant is possible at M+2.
REQ-031 At most one transaction outstanding; req_valid not granted is ignored (requester holds it).
REQ-032 Outside CFG_* and XFER, bus_wen=bus_ren=0 and bus_addr=bus_wdata=0.
REQ-033 rsp_rdata is zero for writes.

Reset
REQ-034 nReset=1 at a clock edge forces CFG_BAUD and clears pending config, cfg_done, cfg_err, arbitration priority (to requester 0), all capture registers, req_ready, rsp_valid, and all bus outputs.
REQ-035 Reset mid-transaction abandons it with no rsp_valid; configuration restarts with BAUD_RESET.

Structure
REQ-036 Package uart_pkg holds UART_RX_ADDR=0, UART_TX_ADDR=4, UART_CTRL_ADDR=20, UART_BAUD_ADDR=24, and the FSM state enum.
REQ-037 Sub-module uart_rr_arb: 2-way round-robin arbiter (valid in, one-hot grant, priority update on accept).

Verification
REQ-038 Reset release, stall=0: bus writes 32'h18 to addr 24, then 32'h0 to addr 20 on consecutive cycles; cfg_done=1 the next cycle.
REQ-039 Both req_valid=1 continuously after config: grants alternate 0,1,0,1; each rsp_valid follows its req_ready by 2 cycles.
REQ-040 Read of addr 0 with stall=1 for 3 cycles and bus_rdata=32'hA5: bus signals stable for 4 cycles; rsp_rdata=32'hA5.
REQ-041 cfg_start with cfg_baud=16'h0145 during an XFER: transaction completes, then bus writes 32'h145 to addr 24 before the next grant.
REQ-042 bus_error=1 on the CFG_BAUD completion: cfg_err=1 remains set; CFG_CTRL write still occurs.
REQ-043 nReset=1 during XFER: no rsp_valid; the bus restarts the write of 32'h18 to addr 24.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus scheduler: register map and FSM state encoding.
package uart_pkg;

    localparam logic [31:0] UART_RX_ADDR   = 32'd0;
    localparam logic [31:0] UART_TX_ADDR   = 32'd4;
    localparam logic [31:0] UART_CTRL_ADDR = 32'd20;
    localparam logic [31:0] UART_BAUD_ADDR = 32'd24;

    typedef enum logic [2:0] {
        StCfgBaud,
        StCfgCtrl,
        StIdle,
        StXfer,
        StResp
    } state_e;

endpackage

// File: rtl/uart_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, priority passes to the loser on every grant.
module uart_rr_arb (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic prio_q, prio_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            if (!prio_q) begin
                if (valid_i[0])      grant_o = 2'b01;
                else if (valid_i[1]) grant_o = 2'b10;
            end else begin
                if (valid_i[1])      grant_o = 2'b10;
                else if (valid_i[0]) grant_o = 2'b01;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (grant_o[0])      prio_d = 1'b1;
        else if (grant_o[1]) prio_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) prio_q <= 1'b0;
        else       prio_q <= prio_d;
    end

endmodule

// File: rtl/uart_bus_sched.sv
// Schedules UART peripheral bus traffic: configuration writes after reset or on request,
// then round-robin single-outstanding transactions from two requesters.
module uart_bus_sched
    import uart_pkg::*;
#(
    parameter logic [15:0] BAUD_RESET = 16'd24,
    parameter logic [31:0] CTRL_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    input  logic        cfg_start,
    input  logic [15:0] cfg_baud,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_wen,
    output logic        bus_ren,
    output logic [3:0]  bus_strobe,
    input  logic [31:0] bus_rdata,
    input  logic        bus_request_stall,
    input  logic        bus_error
);

    state_e      state_q, state_d;
    logic        pending_q, pending_d;
    logic [15:0] div_q, div_d;
    logic        cfg_done_q, cfg_done_d;
    logic        cfg_err_q, cfg_err_d;
    logic        idx_q, idx_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic        bus_wen_q, bus_wen_d;
    logic        bus_ren_q, bus_ren_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;

    logic        arb_en;
    logic [1:0]  arb_grant;
    logic        gnt_idx;

    uart_rr_arb u_arb (
        .clk_i   (clk),
        .rst_i   (nReset),
        .en_i    (arb_en),
        .valid_i (req_valid),
        .grant_o (arb_grant)
    );

    assign gnt_idx = arb_grant[1];

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        div_d       = div_q;
        cfg_done_d  = cfg_done_q;
        cfg_err_d   = cfg_err_q;
        idx_d       = idx_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        bus_wen_d   = bus_wen_q;
        bus_ren_d   = bus_ren_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        arb_en      = 1'b0;
        req_ready   = 2'b00;

        if (cfg_start) begin
            pending_d  = 1'b1;
            div_d      = cfg_baud;
            cfg_done_d = 1'b0;
        end

        unique case (state_q)
            StCfgBaud: begin
                if (bus_wen_q && !bus_request_stall) begin
                    if (bus_error) cfg_err_d = 1'b1;
                    state_d     = StCfgCtrl;
                    bus_addr_d  = UART_CTRL_ADDR;
                    bus_wdata_d = CTRL_RESET;
                end else if (!bus_wen_q) begin
                    // First cycle after reset: the bus is still idle, launch the baud write.
                    bus_wen_d   = 1'b1;
                    bus_addr_d  = UART_BAUD_ADDR;
                    bus_wdata_d = {16'h0, div_q};
                end
            end
            StCfgCtrl: begin
                if (!bus_request_stall) begin
                    if (bus_error) cfg_err_d = 1'b1;
                    state_d     = StIdle;
                    cfg_done_d  = !pending_d;
                    bus_wen_d   = 1'b0;
                    bus_addr_d  = 32'h0;
                    bus_wdata_d = 32'h0;
                end
            end
            StIdle: begin
                if (pending_q) begin
                    if (!cfg_start) pending_d = 1'b0;
                    state_d     = StCfgBaud;
                    bus_wen_d   = 1'b1;
                    bus_addr_d  = UART_BAUD_ADDR;
                    bus_wdata_d = {16'h0, div_q};
                end else begin
                    arb_en = 1'b1;
                    if (|arb_grant) begin
                        req_ready   = arb_grant;
                        idx_d       = gnt_idx;
                        state_d     = StXfer;
                        bus_wen_d   = req_wen[gnt_idx];
                        bus_ren_d   = !req_wen[gnt_idx];
                        bus_addr_d  = gnt_idx ? req_addr[63:32] : req_addr[31:0];
                        bus_wdata_d = gnt_idx ? req_wdata[63:32] : req_wdata[31:0];
                    end
                end
            end
            StXfer: begin
                if (!bus_request_stall) begin
                    rsp_valid_d[idx_q] = 1'b1;
                    rsp_rdata_d = bus_wen_q ? 32'h0 : bus_rdata;
                    rsp_error_d = bus_error;
                    state_d     = StResp;
                    bus_wen_d   = 1'b0;
                    bus_ren_d   = 1'b0;
                    bus_addr_d  = 32'h0;
                    bus_wdata_d = 32'h0;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StCfgBaud;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (nReset) begin
            state_q     <= StCfgBaud;
            pending_q   <= 1'b0;
            div_q       <= BAUD_RESET;
            cfg_done_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
            idx_q       <= 1'b0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
            bus_wen_q   <= 1'b0;
            bus_ren_q   <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            div_q       <= div_d;
            cfg_done_q  <= cfg_done_d;
            cfg_err_q   <= cfg_err_d;
            idx_q       <= idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            bus_wen_q   <= bus_wen_d;
            bus_ren_q   <= bus_ren_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_error  = rsp_error_q;
    assign cfg_done   = cfg_done_q;
    assign cfg_err    = cfg_err_q;
    assign bus_wen    = bus_wen_q;
    assign bus_ren    = bus_ren_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_strobe = (bus_wen_q || bus_ren_q) ? 4'hF : 4'h0;

endmodule

// File: tb/tb_uart_bus_sched.sv
// Bench for uart_bus_sched: scripted configuration/arbitration scenarios with a response
// scoreboard filled on each accepted request and drained on each completion.
module tb_uart_bus_sched;

    logic        clk = 1'b0;
    logic        nReset;
    logic [1:0]  req_valid, req_wen, req_ready, rsp_valid;
    logic [63:0] req_addr, req_wdata;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata, bus_rdata;
    logic        rsp_error, cfg_start, cfg_done, cfg_err, bus_wen, bus_ren;
    logic        bus_request_stall, bus_error;
    logic [15:0] cfg_baud;
    logic [3:0]  bus_strobe;

    typedef struct {
        logic        idx;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   grant_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   rsp_cnt = 0;
    logic lat_chk = 1'b0;
    logic plan_err = 1'b0;
    exp_t mon_e, mon_p;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral read model: address-dependent pattern, 32'hA5 at address 0.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return 32'h0000_00A5 ^ (a << 8);
    endfunction

    assign bus_rdata = mem_rd(bus_addr);

    uart_bus_sched #(
        .BAUD_RESET (16'd24),
        .CTRL_RESET (32'h0)
    ) dut (
        .clk               (clk),
        .nReset            (nReset),
        .req_valid         (req_valid),
        .req_wen           (req_wen),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_error         (rsp_error),
        .cfg_start         (cfg_start),
        .cfg_baud          (cfg_baud),
        .cfg_done          (cfg_done),
        .cfg_err           (cfg_err),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_wen           (bus_wen),
        .bus_ren           (bus_ren),
        .bus_strobe        (bus_strobe),
        .bus_rdata         (bus_rdata),
        .bus_request_stall (bus_request_stall),
        .bus_error         (bus_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nReset == 1'b0) begin
            if (|req_ready) begin
                mon_e.idx   = req_ready[1];
                mon_e.rdata = req_wen[req_ready[1]] ? 32'h0 :
                              mem_rd(req_ready[1] ? req_addr[63:32] : req_addr[31:0]);
                mon_e.err   = plan_err;
                mon_e.cyc   = cyc;
                sb.push_back(mon_e);
                grant_q.push_back(req_ready[1] ? 1 : 0);
            end
            if (|rsp_valid) begin
                rsp_cnt++;
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", {30'h0, rsp_valid}, 32'h0);
                end else begin
                    mon_p = sb.pop_front();
                    check_eq("rsp_idx", {30'h0, rsp_valid}, mon_p.idx ? 32'h2 : 32'h1);
                    check_eq("rsp_rdata", rsp_rdata, mon_p.rdata);
                    check_eq("rsp_error", {31'h0, rsp_error}, {31'h0, mon_p.err});
                    if (lat_chk) check_eq("rsp_latency", cyc - mon_p.cyc, 32'd2);
                end
            end
        end
    end

    task automatic wait_grant(input string tag);
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (|req_ready) break;
        end
        check_eq(tag, {31'h0, n < 50}, 32'h1);
    endtask

    task automatic wait_cfg_done(input string tag);
        int n;
        for (n = 0; n < 50; n++) begin
            @(negedge clk); #1;
            if (cfg_done) break;
        end
        check_eq(tag, {31'h0, cfg_done}, 32'h1);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) break;
        end
        check_eq(tag, sb.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   rsp_before;
        logic found, saw;

        nReset = 1'b1; req_valid = 2'b11; req_wen = 2'b00; req_addr = '0; req_wdata = '0;
        cfg_start = 1'b0; cfg_baud = 16'h0; bus_request_stall = 1'b0; bus_error = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cfg_done", {31'h0, cfg_done}, 32'h0);
        check_eq("rst_cfg_err", {31'h0, cfg_err}, 32'h0);
        check_eq("rst_bus_en", {30'h0, bus_wen, bus_ren}, 32'h0);
        check_eq("rst_bus_addr", bus_addr, 32'h0);
        check_eq("rst_req_ready", {30'h0, req_ready}, 32'h0);
        check_eq("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);

        // Power-up configuration sequence
        @(posedge clk); #1 nReset = 1'b0; req_valid = 2'b00;
        @(negedge clk);
        check_eq("rel_bus_idle", {31'h0, bus_wen}, 32'h0);
        @(negedge clk);
        check_eq("cfg_baud_wen", {30'h0, bus_wen, bus_ren}, 32'h2);
        check_eq("cfg_baud_addr", bus_addr, 32'd24);
        check_eq("cfg_baud_data", bus_wdata, 32'h18);
        check_eq("cfg_baud_strobe", {28'h0, bus_strobe}, 32'hF);
        @(negedge clk);
        check_eq("cfg_ctrl_wen", {31'h0, bus_wen}, 32'h1);
        check_eq("cfg_ctrl_addr", bus_addr, 32'd20);
        check_eq("cfg_ctrl_data", bus_wdata, 32'h0);
        check_eq("cfg_ctrl_done", {31'h0, cfg_done}, 32'h0);
        @(negedge clk);
        check_eq("cfg_done_set", {31'h0, cfg_done}, 32'h1);
        check_eq("cfg_idle_bus", {31'h0, bus_wen}, 32'h0);
        check_eq("cfg_idle_addr", bus_addr, 32'h0);

        // Round-robin with both requesters asserting
        lat_chk = 1'b1;
        @(posedge clk); #1;
        req_valid = 2'b11; req_wen = 2'b01;
        req_addr = {32'd0, 32'd4}; req_wdata = {32'h0, 32'h11};
        for (int n = 0; n < 40 && grant_q.size() < 4; n++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 req_valid = 2'b00;
        if (grant_q.size() >= 4) begin
            check_eq("rr_g0", grant_q[0], 32'd0);
            check_eq("rr_g1", grant_q[1], 32'd1);
            check_eq("rr_g2", grant_q[2], 32'd0);
            check_eq("rr_g3", grant_q[3], 32'd1);
        end else begin
            check_eq("rr_grant_count", grant_q.size(), 32'd4);
        end
        wait_drain("rr_drain");
        lat_chk = 1'b0;

        // Stalled read with bus error on completion
        @(posedge clk); #1;
        bus_request_stall = 1'b1; plan_err = 1'b1;
        req_valid = 2'b01; req_wen = 2'b00; req_addr = {32'd0, 32'd0};
        wait_grant("stall_grant");
        @(posedge clk); #1 req_valid = 2'b00; plan_err = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 3) begin
                bus_request_stall = 1'b0; bus_error = 1'b1;
            end
            @(negedge clk);
            check_eq("stall_bus_en", {30'h0, bus_wen, bus_ren}, 32'h1);
            check_eq("stall_bus_addr", bus_addr, 32'h0);
            check_eq("stall_strobe", {28'h0, bus_strobe}, 32'hF);
        end
        @(posedge clk); #1 bus_error = 1'b0;
        @(negedge clk); #1;
        check_eq("stall_rsp_valid", {30'h0, rsp_valid}, 32'h1);
        check_eq("stall_rsp_rdata", rsp_rdata, 32'hA5);
        check_eq("stall_rsp_err", {31'h0, rsp_error}, 32'h1);
        wait_drain("stall_drain");

        // Reconfiguration requested during a transaction
        @(posedge clk); #1;
        bus_request_stall = 1'b1;
        req_valid = 2'b01; req_wen = 2'b01;
        req_addr = {32'd4, 32'd4}; req_wdata = {32'h0, 32'h22};
        wait_grant("recfg_grant");
        @(posedge clk); #1;
        req_valid = 2'b10; req_wen = 2'b00; cfg_start = 1'b1; cfg_baud = 16'h0145;
        @(negedge clk);
        check_eq("recfg_xfer_wen", {31'h0, bus_wen}, 32'h1);
        check_eq("recfg_xfer_addr", bus_addr, 32'd4);
        check_eq("recfg_xfer_data", bus_wdata, 32'h22);
        @(posedge clk); #1 cfg_start = 1'b0; bus_request_stall = 1'b0;
        @(negedge clk);
        check_eq("recfg_done_clr", {31'h0, cfg_done}, 32'h0);
        found = 1'b0; saw = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (|req_ready) saw = 1'b1;
            if (bus_wen && bus_addr == 32'd24) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("recfg_baud_seen", {31'h0, found}, 32'h1);
        check_eq("recfg_baud_data", bus_wdata, 32'h145);
        check_eq("recfg_no_early_grant", {31'h0, saw}, 32'h0);
        wait_grant("recfg_next_grant");
        check_eq("recfg_done_at_grant", {31'h0, cfg_done}, 32'h1);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_drain("recfg_drain");

        // Bus error on the baud write of a configuration run
        check_eq("cfgerr_pre", {31'h0, cfg_err}, 32'h0);
        @(posedge clk); #1 cfg_start = 1'b1; cfg_baud = 16'd24;
        @(posedge clk); #1 cfg_start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus_wen && bus_addr == 32'd24) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("cfgerr_baud_seen", {31'h0, found}, 32'h1);
        bus_error = 1'b1;
        @(posedge clk); #1 bus_error = 1'b0;
        @(negedge clk);
        check_eq("cfgerr_ctrl_wen", {31'h0, bus_wen}, 32'h1);
        check_eq("cfgerr_ctrl_addr", bus_addr, 32'd20);
        check_eq("cfgerr_set", {31'h0, cfg_err}, 32'h1);
        wait_cfg_done("cfgerr_done");
        check_eq("cfgerr_sticky", {31'h0, cfg_err}, 32'h1);

        // Reset in the middle of a transaction
        @(posedge clk); #1;
        bus_request_stall = 1'b1;
        req_valid = 2'b01; req_wen = 2'b00; req_addr = {32'd0, 32'd0};
        wait_grant("rstx_grant");
        @(posedge clk); #1 req_valid = 2'b00;
        @(negedge clk);
        check_eq("rstx_xfer_ren", {31'h0, bus_ren}, 32'h1);
        rsp_before = rsp_cnt;
        @(posedge clk); #1 nReset = 1'b1;
        @(negedge clk);
        check_eq("rstx_rsp_in_rst", {30'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1 nReset = 1'b0; bus_request_stall = 1'b0; sb.delete();
        @(negedge clk);
        check_eq("rstx_bus_idle", {30'h0, bus_wen, bus_ren}, 32'h0);
        check_eq("rstx_cfg_err_clr", {31'h0, cfg_err}, 32'h0);
        @(negedge clk);
        check_eq("rstx_baud_wen", {31'h0, bus_wen}, 32'h1);
        check_eq("rstx_baud_addr", bus_addr, 32'd24);
        check_eq("rstx_baud_data", bus_wdata, 32'h18);
        wait_cfg_done("rstx_cfg_done");
        repeat (3) @(negedge clk);
        check_eq("rstx_no_rsp", rsp_cnt, rsp_before);
        check_eq("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
